cache_mem_arbiter: RTL and testbench



---
 rtl/cache_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the physical-memory line port between the icache
// and the dcache. One grant at a time, held until pmem_resp, with the response
// routed back combinationally. Wrapping per-requester completion counters
// feed the performance bench.
// Optional feature: define CACHE_ARB_ROUND_ROBIN_EN to alternate priority
// under contention; otherwise the dcache always wins a tie.
//
// state   | meaning
// IDLE    | no strobes; arbitrate and latch the winner's request
// SERVE_I | icache line read in flight
// SERVE_D | dcache line read or write-back in flight
module cache_mem_arbiter #(
    parameter int LINE_WIDTH  = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [31:0]           i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [31:0]           d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [31:0]           pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [31:0]           i_grant_count,
    output logic [31:0]           d_grant_count
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic [31:0]           i_cnt_q, d_cnt_q;
    logic                  d_req;
    logic                  pick_d;

    assign d_req = d_read | d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic last_d_q;

    // under contention, favour whichever requester was not served last
    always_comb pick_d = d_req && (!i_read || !last_d_q);

    // remember who completed most recently; reset means icache
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_d_q <= 1'b0;
        else if (i_resp)
            last_d_q <= 1'b0;
        else if (d_resp)
            last_d_q <= 1'b1;
    end
`else
    // fixed priority: the MEM stage must not stall behind an IF refill
    always_comb pick_d = d_req;
`endif

    // next-state, request capture and strobe/response decode
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = SERVE_D;
                    addr_d  = d_address;
                    wdata_d = d_wdata;
                    wr_d    = d_write;
                end else if (i_read) begin
                    state_d = SERVE_I;
                    addr_d  = i_address;
                    wr_d    = 1'b0;
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            SERVE_D: begin
                pmem_read  = !wr_q;
                pmem_write = wr_q;
                if (pmem_resp) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and latched request; reset abandons any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    // completion counters, wrapping naturally at 32 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_cnt_q <= '0;
            d_cnt_q <= '0;
        end else begin
            if (i_resp)
                i_cnt_q <= i_cnt_q + 32'd1;
            if (d_resp)
                d_cnt_q <= d_cnt_q + 32'd1;
        end
    end

    assign pmem_address  = {addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign pmem_wdata    = wdata_q;
    assign i_rdata       = pmem_rdata;
    assign d_rdata       = pmem_rdata;
    assign i_grant_count = i_cnt_q;
    assign d_grant_count = d_cnt_q;

    // a simultaneous dcache read and write is a cache bug; the write is served
    rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: single transactions, contention order,
// async reset mid-transaction, counter wrap and a spurious memory response.
module tb_cache_mem_arbiter;

    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write, pmem_resp;
    logic [31:0]   i_address, d_address;
    logic [LW-1:0] d_wdata, pmem_rdata;
    logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
    logic          i_resp, d_resp, pmem_read, pmem_write;
    logic [31:0]   pmem_address, i_grant_count, d_grant_count;

    int            n_chk  = 0;
    int            n_pass = 0;
    logic [31:0]   exp_i_cnt = 0;
    logic [31:0]   exp_d_cnt = 0;
    logic          last_d_m  = 1'b0;

    cache_mem_arbiter #(.LINE_WIDTH(LW), .OFFSET_BITS(5)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called at the negedge of the first serve cycle. Models a memory of
    // latency lat: strobe high for lat cycles, pmem_resp in the last one,
    // during which the granted cache drops its request.
    task automatic do_txn(input int lat, input logic is_d, input logic is_wr,
                          input logic [31:0] exp_addr, input logic [LW-1:0] rd);
        for (int k = 1; k <= lat; k++) begin
            chk("pmem_read", pmem_read, !is_wr);
            chk("pmem_write", pmem_write, is_wr);
            chk("pmem_address", pmem_address, exp_addr);
            if (k == lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rd;
                if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
                else i_read = 1'b0;
                #1;
                chk("i_resp", i_resp, !is_d);
                chk("d_resp", d_resp, is_d);
                chk("rdata", is_d ? d_rdata : i_rdata, rd);
            end
            @(negedge clk);
        end
        pmem_resp = 1'b0;
        if (is_d) exp_d_cnt = exp_d_cnt + 1;
        else      exp_i_cnt = exp_i_cnt + 1;
        last_d_m = is_d;
        chk("i_resp_after", i_resp, 1'b0);
        chk("d_resp_after", d_resp, 1'b0);
        chk("i_grant_count", i_grant_count, exp_i_cnt);
        chk("d_grant_count", d_grant_count, exp_d_cnt);
    endtask

    initial begin
        logic first_d;
        rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
        i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_address", pmem_address, 32'h0);
        chk("rst_wdata", pmem_wdata, '0);
        chk("rst_i_cnt", i_grant_count, 32'h0);
        chk("rst_d_cnt", d_grant_count, 32'h0);
        rst = 1'b0;

        // icache read, latency 3
        @(negedge clk);
        i_read = 1'b1; i_address = 32'h0000_1234;
        @(negedge clk);
        do_txn(3, 1'b0, 1'b0, 32'h0000_1220, {8{32'hCAFE_0001}});
        chk("idle_read", pmem_read, 1'b0);

        // dcache write-back, latency 2
        d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = {32{8'hA5}};
        @(negedge clk);
        chk("pmem_wdata", pmem_wdata, {32{8'hA5}});
        do_txn(2, 1'b1, 1'b1, 32'h8000_0040, {8{32'h1111_2222}});
        chk("idle_write", pmem_write, 1'b0);

        // contended read pairs
        for (int p = 0; p < 4; p++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            first_d = !last_d_m;
`else
            first_d = 1'b1;
`endif
            i_read = 1'b1; i_address = 32'h0000_2000 + p * 32'h100;
            d_read = 1'b1; d_address = 32'h4000_0000 + p * 32'h100;
            @(negedge clk);
            do_txn(1 + p, first_d, 1'b0,
                   first_d ? 32'h4000_0000 + p * 32'h100 : 32'h0000_2000 + p * 32'h100,
                   {8{32'hD0D0_0000 + p}});
            chk("bubble_read", pmem_read, 1'b0);
            @(negedge clk);
            do_txn(2, !first_d, 1'b0,
                   first_d ? 32'h0000_2000 + p * 32'h100 : 32'h4000_0000 + p * 32'h100,
                   {8{32'h1C1C_0000 + p}});
        end

        // async reset in the middle of a dcache read
        d_read = 1'b1; d_address = 32'h0000_3000;
        @(negedge clk);
        chk("serve_d_read", pmem_read, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_read", pmem_read, 1'b0);
        chk("arst_write", pmem_write, 1'b0);
        chk("arst_i_cnt", i_grant_count, 32'h0);
        chk("arst_d_cnt", d_grant_count, 32'h0);
        chk("arst_address", pmem_address, 32'h0);
        exp_i_cnt = 0; exp_d_cnt = 0; last_d_m = 1'b0;
        d_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", pmem_read, 1'b0);
        i_read = 1'b1; i_address = 32'h0000_5678;
        @(negedge clk);
        do_txn(2, 1'b0, 1'b0, 32'h0000_5660, {8{32'h5555_AAAA}});

        // counter wrap
        force dut.d_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.d_cnt_q;
        #1;
        chk("preload", d_grant_count, 32'hFFFF_FFFF);
        exp_d_cnt = 32'hFFFF_FFFF;
        d_read = 1'b1; d_address = 32'h0000_7000;
        @(negedge clk);
        do_txn(1, 1'b1, 1'b0, 32'h0000_7000, {8{32'h7777_0000}});
        chk("wrap", d_grant_count, 32'h0);

        // spurious response in IDLE
        pmem_resp = 1'b1;
        #1;
        chk("spur_i_resp", i_resp, 1'b0);
        chk("spur_d_resp", d_resp, 1'b0);
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("spur_i_cnt", i_grant_count, exp_i_cnt);
        chk("spur_d_cnt", d_grant_count, exp_d_cnt);
        chk("spur_read", pmem_read, 1'b0);
        chk("spur_write", pmem_write, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
